// File: rtl/project_types.sv
// Shared CPU-core types: memory byte-enable width and the memory arbiter FSM states.
package project_types;

  localparam int BYTE_SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store,
// with data priority and per-requester done flags so a frozen requester is not re-served.
module mem_arbiter
  import project_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ce,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_data,
  output logic                  inst_stallreq,
  input  logic                  inst_advance,
  input  logic                  data_ce,
  input  logic                  data_we,
  input  logic [BYTE_SEL_W-1:0] data_sel,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_stallreq,
  input  logic                  data_advance,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BYTE_SEL_W-1:0] mem_sel,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  arb_state_t state;
  logic       inst_done;
  logic       data_done;
  logic       inst_pend;
  logic       data_pend;
  logic       grant_data;
  logic       grant_inst;
  logic       finish;
  logic       inst_ack;
  logic       data_ack;

  assign inst_pend = inst_ce & ~inst_done;
  assign data_pend = data_ce & ~data_done;

  assign inst_stallreq = ~rst & inst_pend;
  assign data_stallreq = ~rst & data_pend;

  assign inst_ack = (state == ARB_INST) & mem_ack;
  assign data_ack = (state == ARB_DATA) & mem_ack;
  assign finish   = inst_ack | data_ack;

  // On an ack the other requester is granted directly, so mem_req never drops between them
  assign grant_data = data_pend & ((state == ARB_IDLE) | inst_ack);
  assign grant_inst = inst_pend & (((state == ARB_IDLE) & ~data_pend) | data_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_data) begin
      state     <= ARB_DATA;
      mem_req   <= 1'b1;
      mem_we    <= data_we;
      mem_sel   <= data_sel;
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
    end else if (grant_inst) begin
      state     <= ARB_INST;
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_sel   <= '1;
      mem_addr  <= inst_addr;
      mem_wdata <= '0;
    end else if (finish) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
    end
  end

  // Done flags hold off re-service until the owning stage advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
    end else begin
      if (inst_advance)  inst_done <= 1'b0;
      else if (inst_ack) inst_done <= 1'b1;
      if (data_advance)  data_done <= 1'b0;
      else if (data_ack) data_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_data  <= '0;
      data_rdata <= '0;
    end else begin
      if (inst_ack)            inst_data  <= mem_rdata;
      if (data_ack && !mem_we) data_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with an in-bench unified RAM model (programmable ack delay).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ce, inst_advance, data_ce, data_we, data_advance;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_sel;
  logic [31:0] inst_data, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        inst_stallreq, data_stallreq, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_sel;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_ce(inst_ce), .inst_addr(inst_addr), .inst_data(inst_data),
    .inst_stallreq(inst_stallreq), .inst_advance(inst_advance),
    .data_ce(data_ce), .data_we(data_we), .data_sel(data_sel), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_stallreq(data_stallreq),
    .data_advance(data_advance),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Unified RAM model: 128 words, fetches below 0x100, data at 0x100..0x1FC
  logic [31:0] ram [0:127];
  int          wait_cnt;
  int          rnd_delay;
  int          ack_delay;
  bit          ack_hold;
  bit          rand_delay;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h2401_0005;
      5:       return 32'h8C22_0004;
      64:      return 32'hDEAD_BEEF;
      default: return {16'hA5A5, 16'(i)};
    endcase
  endfunction

  assign mem_ack   = mem_req && !ack_hold && (wait_cnt == (rand_delay ? rnd_delay : ack_delay));
  assign mem_rdata = ram[mem_addr[8:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= 0;
      rnd_delay <= 0;
      for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
    end else if (mem_req) begin
      if (mem_ack) begin
        wait_cnt  <= 0;
        rnd_delay <= int'($urandom_range(0, 5));
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_sel[b]) ram[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        inst_q[$];
  exp_t        data_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [0:127];
  logic [31:0] last_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic init_ref();
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    last_load = 32'h0;
  endtask

  task automatic push_inst(input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    e.we = 1'b0; e.sel = 4'hF; e.addr = a; e.wdata = 32'h0; e.rdata = rd;
    inst_q.push_back(e);
  endtask

  task automatic push_data(input logic we, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.we = we; e.sel = sel; e.addr = a; e.wdata = wd; e.rdata = rd;
    data_q.push_back(e);
  endtask

  // Random-phase expectations come from the reference memory, tracked in program order
  task automatic push_data_rand();
    logic [31:0] w;
    w = ref_mem[data_addr[8:2]];
    if (data_we) begin
      for (int b = 0; b < 4; b++)
        if (data_sel[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
      ref_mem[data_addr[8:2]] = w;
      push_data(1'b1, data_sel, data_addr, data_wdata, last_load);
    end else begin
      last_load = w;
      push_data(1'b0, data_sel, data_addr, 32'h0, w);
    end
  endtask

  // Monitor: pop the expected entry on every completed memory transaction
  bit          chk_i = 1'b0;
  bit          chk_d = 1'b0;
  logic [31:0] exp_i, exp_d;
  int          fetch_while_data = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_i) begin check("mon_inst_data", inst_data, exp_i); chk_i = 1'b0; end
      if (chk_d) begin check("mon_data_rdata", data_rdata, exp_d); chk_d = 1'b0; end
      if (rst) fetch_while_data = 0;
      if (!rst && mem_req && mem_ack) begin
        if (!mem_addr[8]) begin
          if (data_stallreq) fetch_while_data++;
          if (inst_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon_unexpected_fetch actual_addr=%h required=none", mem_addr);
          end else begin
            e = inst_q.pop_front();
            check("mon_fetch_addr", mem_addr, e.addr);
            check("mon_fetch_cmd", 32'({mem_we, mem_sel}), 32'({1'b0, 4'hF}));
            exp_i = e.rdata; chk_i = 1'b1;
          end
        end else begin
          check("mon_data_starved", 32'(fetch_while_data > 1), 32'd0);
          fetch_while_data = 0;
          if (data_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon_unexpected_data actual_addr=%h required=none", mem_addr);
          end else begin
            e = data_q.pop_front();
            check("mon_data_addr", mem_addr, e.addr);
            check("mon_data_cmd", 32'({mem_we, mem_sel}), 32'({e.we, e.sel}));
            if (e.we) check("mon_data_wdata", mem_wdata, e.wdata);
            exp_d = e.rdata; chk_d = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic retire_inst();
    inst_advance = 1'b1; inst_ce = 1'b0;
    tick();
    inst_advance = 1'b0;
  endtask

  task automatic retire_data();
    data_advance = 1'b1; data_ce = 1'b0; data_we = 1'b0;
    tick();
    data_advance = 1'b0;
  endtask

  int  icnt, dcnt, rcnt, rises, lacks, bad;
  bit  prev_req, adv_i, adv_d, stop_new, stall_any;

  initial begin
    inst_ce = 0; inst_addr = 0; inst_advance = 0;
    data_ce = 0; data_we = 0; data_sel = 0; data_addr = 0; data_wdata = 0; data_advance = 0;
    ack_delay = 0; ack_hold = 0; rand_delay = 0;
    init_ref();
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    #10 rst = 1'b0;
    tick();

    // Fetch only, zero-wait memory
    inst_ce = 1'b1; inst_addr = 32'h10;
    push_inst(32'h10, 32'h2401_0005);
    icnt = 0; rcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); icnt += int'(inst_stallreq); rcnt += int'(mem_req);
      tick();
    end
    check("t1_inst_stall_cycles", 32'(icnt), 32'd2);
    check("t1_mem_req_cycles", 32'(rcnt), 32'd1);
    check("t1_inst_data", inst_data, 32'h2401_0005);
    retire_inst();

    // Simultaneous fetch and load, 2-wait memory
    ack_delay = 2;
    inst_ce = 1'b1; inst_addr = 32'h14;
    data_ce = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h100;
    push_data(1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF);
    push_inst(32'h14, 32'h8C22_0004);
    icnt = 0; dcnt = 0; rcnt = 0; rises = 0; lacks = 0; prev_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      icnt += int'(inst_stallreq); dcnt += int'(data_stallreq); rcnt += int'(mem_req);
      if (mem_req && !prev_req) rises++;
      if (mem_req && mem_ack && mem_addr == 32'h100) lacks++;
      prev_req = mem_req;
      tick();
    end
    check("t2_data_stall_cycles", 32'(dcnt), 32'd4);
    check("t2_inst_stall_cycles", 32'(icnt), 32'd7);
    check("t2_mem_req_cycles", 32'(rcnt), 32'd6);
    check("t2_mem_req_rises", 32'(rises), 32'd1);
    check("t2_load_issued", 32'(lacks), 32'd1);
    check("t2_data_rdata", data_rdata, 32'hDEAD_BEEF);
    check("t2_inst_data", inst_data, 32'h8C22_0004);
    retire_inst(); retire_data();

    // Partial store, then read it back
    ack_delay = 1;
    data_ce = 1'b1; data_we = 1'b1; data_sel = 4'b0011; data_addr = 32'h120; data_wdata = 32'h1234_5678;
    push_data(1'b1, 4'b0011, 32'h120, 32'h1234_5678, 32'hDEAD_BEEF);
    bad = 0; rcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req) begin
        rcnt++;
        if (!(mem_we && mem_sel == 4'b0011)) bad++;
      end
      tick();
    end
    check("t3_store_cmd_bad_cycles", 32'(bad), 32'd0);
    check("t3_store_req_cycles", 32'(rcnt), 32'd2);
    check("t3_data_rdata_kept", data_rdata, 32'hDEAD_BEEF);
    retire_data();
    ack_delay = 0;
    data_ce = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h120;
    push_data(1'b0, 4'hF, 32'h120, 32'h0, 32'hA5A5_5678);
    for (int c = 0; c < 4; c++) tick();
    check("t3_readback", data_rdata, 32'hA5A5_5678);
    retire_data();

    // Asynchronous reset in the middle of a withheld grant
    ack_hold = 1'b1;
    data_ce = 1'b1; data_we = 1'b1; data_sel = 4'hF; data_addr = 32'h130; data_wdata = 32'hFFFF_FFFF;
    tick(); tick();
    check("t5_pre_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_mem_req", 32'(mem_req), 32'd0);
    check("t5_mem_we", 32'(mem_we), 32'd0);
    check("t5_mem_sel", 32'(mem_sel), 32'd0);
    check("t5_mem_addr", mem_addr, 32'h0);
    check("t5_mem_wdata", mem_wdata, 32'h0);
    check("t5_inst_data", inst_data, 32'h0);
    check("t5_data_rdata", data_rdata, 32'h0);
    check("t5_data_stallreq", 32'(data_stallreq), 32'd0);
    data_ce = 0; data_we = 0; data_sel = 0; data_addr = 0; data_wdata = 0;
    ack_hold = 1'b0; ack_delay = 0;
    init_ref();
    #10 rst = 1'b0;
    tick();
    inst_ce = 1'b1; inst_addr = 32'h10;
    push_inst(32'h10, 32'h2401_0005);
    icnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); icnt += int'(inst_stallreq);
      tick();
    end
    check("t5_fetch_stall_cycles", 32'(icnt), 32'd2);
    check("t5_fetch_data", inst_data, 32'h2401_0005);
    retire_inst();

    // Random requests and advances with random ack delay
    rand_delay = 1'b1;
    adv_i = 1'b1; adv_d = 1'b1;
    for (int c = 0; c < 10100; c++) begin
      stop_new = (c >= 10000);
      if (adv_i) begin
        inst_ce   = !stop_new && ($urandom_range(0, 3) != 0);
        inst_addr = 32'($urandom_range(0, 63)) << 2;
        if (inst_ce) push_inst(inst_addr, ref_mem[inst_addr[8:2]]);
      end
      if (adv_d) begin
        data_ce    = !stop_new && ($urandom_range(0, 2) != 0);
        data_we    = 1'($urandom_range(0, 1));
        data_sel   = 4'($urandom_range(1, 15));
        data_addr  = 32'h100 + (32'($urandom_range(0, 63)) << 2);
        data_wdata = $urandom();
        if (data_ce) push_data_rand();
      end
      #1;
      stall_any    = inst_stallreq || data_stallreq;
      inst_advance = !stall_any && ($urandom_range(0, 2) != 0);
      data_advance = !stall_any && ($urandom_range(0, 2) != 0);
      adv_i = inst_advance; adv_d = data_advance;
      tick();
    end
    inst_advance = 1'b0; data_advance = 1'b0;
    tick(); tick();
    check("rnd_inst_q_left", 32'(inst_q.size()), 32'd0);
    check("rnd_data_q_left", 32'(data_q.size()), 32'd0);
    check("rnd_final_stall", 32'({inst_stallreq, data_stallreq}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
